// File: rtl/trng_postproc.sv
// Ring-oscillator TRNG consumer: warmup, parity fold, repetition-count test,
// von Neumann debias, word packing and an output FIFO with valid/ready read.
module trng_postproc #(
    parameter int SIZE       = 8,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int WARMUP_CYC = 64,
    parameter int RCT_LIMIT  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr_alarm,
    input  logic [SIZE-1:0]               raw_in,
    output logic                          ro_en,
    output logic [WORD_W-1:0]             rnd_data,
    output logic                          rnd_valid,
    input  logic                          rnd_ready,
    output logic                          alarm,
    output logic [$clog2(FIFO_DEPTH)+1-1:0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WARMUP_CYC + 1);
    localparam int RW = $clog2(RCT_LIMIT + 1);
    localparam int BW = $clog2(WORD_W + 1);

    localparam logic [CW-1:0] WLOAD = CW'(WARMUP_CYC - 1);
    localparam logic [RW-1:0] RLIM  = RW'(RCT_LIMIT);
    localparam logic [BW-1:0] WFULL = BW'(WORD_W);
    localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN,
        ALARM
    } state_t;

    state_t            state;
    logic [CW-1:0]     wcnt;
    logic [RW-1:0]     rct_cnt;
    logic              prev_fb;
    logic              vn_have;
    logic              vn_bit;
    logic [WORD_W-1:0] sreg;
    logic [BW-1:0]     bit_cnt;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;

    logic          fb;
    logic          run;
    logic [RW-1:0] rct_next;
    logic          rct_hit;
    logic          leave;
    logic          hold;
    logic          vn_emit;
    logic          pop;
    logic          push;

    assign fb       = ^raw_in;
    assign run      = (state == RUN);
    assign rct_next = (rct_cnt == '0 || fb != prev_fb) ? RW'(1) : rct_cnt + RW'(1);
    assign rct_hit  = run && (rct_next == RLIM);
    assign leave    = run && (rct_hit || !en);
    assign hold     = (bit_cnt == WFULL);
    assign vn_emit  = run && !leave && vn_have && (vn_bit != fb);

    assign rnd_valid  = (level != '0);
    assign rnd_data   = rnd_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;
    assign pop        = rnd_valid && rnd_ready;
    assign push       = run && !leave && hold && ((level < DEPTH) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ro_en   <= 1'b0;
            alarm   <= 1'b0;
            wcnt    <= '0;
            rct_cnt <= '0;
            prev_fb <= 1'b0;
            vn_have <= 1'b0;
            vn_bit  <= 1'b0;
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= WARMUP;
                        ro_en <= 1'b1;
                        wcnt  <= WLOAD;
                    end
                end
                WARMUP: begin
                    if (!en) begin
                        state <= IDLE;
                        ro_en <= 1'b0;
                    end else if (wcnt == '0) begin
                        state <= RUN;
                    end else begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                RUN: begin
                    if (leave) begin
                        // Any exit from RUN drops the partial word and test history
                        state   <= rct_hit ? ALARM : IDLE;
                        alarm   <= rct_hit;
                        ro_en   <= 1'b0;
                        rct_cnt <= '0;
                        prev_fb <= 1'b0;
                        vn_have <= 1'b0;
                        vn_bit  <= 1'b0;
                        sreg    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        rct_cnt <= rct_next;
                        prev_fb <= fb;
                        vn_have <= !vn_have;
                        if (!vn_have) begin
                            vn_bit <= fb;
                        end
                        if (push) begin
                            bit_cnt <= '0;
                        end else if (vn_emit && !hold) begin
                            sreg    <= {sreg[WORD_W-2:0], vn_bit};
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ALARM: begin
                    if (clr_alarm) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (rct_hit) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sreg;
        end
    end

endmodule

// File: tb/tb_trng_postproc.sv
// Scoreboard bench for trng_postproc: words are queued as their VN pairs
// are driven and compared when the host side pops them.
module tb_trng_postproc;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr_alarm;
    logic [7:0] raw_in;
    logic       ro_en;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       alarm;
    logic [2:0] fifo_level;

    int tests;
    int fails;
    logic [7:0] q[$];

    trng_postproc #(
        .SIZE      (8),
        .WORD_W    (8),
        .FIFO_DEPTH(4),
        .WARMUP_CYC(4),
        .RCT_LIMIT (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr_alarm (clr_alarm),
        .raw_in    (raw_in),
        .ro_en     (ro_en),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .alarm     (alarm),
        .fifo_level(fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mk(input logic b);
        logic [7:0] r;
        r    = 8'($urandom);
        r[0] = r[0] ^ (^r) ^ b;
        return r;
    endfunction

    task automatic drive_fb(input logic b);
        raw_in = mk(b);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        logic [7:0] v;
        v = w;
        q.push_back(w);
        for (int i = 7; i >= 0; i--) begin
            drive_fb(v[i]);
            drive_fb(!v[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_fb(((i >> 1) & 1) == 0);
        end
    endtask

    task automatic enable();
        en = 1'b1;
        @(posedge clk);
        #1;
        check("ro_en_on", ro_en, 1);
        for (int i = 0; i < 4; i++) begin
            drive_fb(1'($urandom));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rnd_valid && rnd_ready) begin
            if (q.size() == 0) begin
                check("sb_extra", 0, 1);
            end else begin
                check("sb_word", rnd_data, q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        clr_alarm = 1'b0;
        rnd_ready = 1'b1;
        raw_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ro_en", ro_en, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_data", rnd_data, 0);
        check("rst_alarm", alarm, 0);
        check("rst_level", fifo_level, 0);
        rst_n = 1'b1;
        drive_fb(1'b0);
        check("idle_ro_en", ro_en, 0);

        // 1: alternating 1,0 gives 0xFF, valid 17 clocks after RUN entry
        enable();
        send_word(8'hFF);
        check("lat_early", rnd_valid, 0);
        drive_fb(1'b1);
        check("lat_valid", rnd_valid, 1);
        drive_fb(1'b1);

        // 2: 0,1 pairs with interleaved 1,1 pairs
        q.push_back(8'h00);
        for (int i = 0; i < 8; i++) begin
            drive_fb(1'b0);
            drive_fb(1'b1);
            drive_fb(1'b1);
            drive_fb(1'b1);
        end
        idle(4);
        check("t2_alarm", alarm, 0);
        check("t2_drain", q.size(), 0);

        // 3: six identical folded bits raise the alarm
        rnd_ready = 1'b0;
        send_word(8'hA4);
        for (int i = 0; i < 5; i++) begin
            drive_fb(1'b0);
        end
        check("rct_below", alarm, 0);
        check("alarm_word", rnd_data, q.pop_front());
        drive_fb(1'b0);
        check("rct_alarm", alarm, 1);
        check("alarm_ro_en", ro_en, 0);
        check("alarm_flush", rnd_valid, 0);
        check("alarm_level", fifo_level, 0);
        idle(3);
        check("alarm_sticky", alarm, 1);
        check("alarm_en_ign", ro_en, 0);
        en        = 1'b0;
        clr_alarm = 1'b1;
        drive_fb(1'b0);
        clr_alarm = 1'b0;
        check("clr_alarm", alarm, 0);
        idle(2);
        check("clr_idle", ro_en, 0);

        // 4: full FIFO holds the fifth word until a pop frees a slot
        enable();
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        send_word(8'h55);
        idle(8);
        check("full_level", fifo_level, 4);
        check("full_head", rnd_data, q[0]);
        rnd_ready = 1'b1;
        drive_fb(1'b1);
        check("pop_push_level", fifo_level, 4);
        drive_fb(1'b1);
        idle(12);
        check("full_drain", q.size(), 0);
        check("drain_level", fifo_level, 0);

        // 5: disable mid-word keeps FIFO, drops partial word
        rnd_ready = 1'b0;
        send_word(8'h3C);
        for (int i = 0; i < 3; i++) begin
            drive_fb(1'b1);
            drive_fb(1'b0);
        end
        en = 1'b0;
        drive_fb(1'b0);
        check("dis_ro_en", ro_en, 0);
        check("dis_level", fifo_level, 1);
        rnd_ready = 1'b1;
        idle(2);
        check("dis_drain", q.size(), 0);
        enable();
        send_word(8'h81);
        idle(4);
        check("reen_drain", q.size(), 0);

        // 6: async reset mid-RUN with queued words and a partial word
        rnd_ready = 1'b0;
        send_word(8'h5A);
        send_word(8'hC3);
        for (int i = 0; i < 3; i++) begin
            drive_fb(1'b0);
            drive_fb(1'b1);
        end
        check("pre_rst_level", fifo_level, 2);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("arst_ro_en", ro_en, 0);
        check("arst_valid", rnd_valid, 0);
        check("arst_data", rnd_data, 0);
        check("arst_level", fifo_level, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        check("post_rst_idle", ro_en, 0);
        rnd_ready = 1'b1;
        enable();
        send_word(8'h96);
        idle(4);
        check("final_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
